// File: rtl/finn_frame_sequencer.sv
// rtl/finn_frame_sequencer.sv - sequences one buffered frame into the FINN IP and captures its result byte
module finn_frame_sequencer #(
    parameter int PIXELS  = 784,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 200000
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] result,
    output logic [15:0]       frame_count,
    output logic [DATA_W-1:0] m_axis_0_tdata,
    output logic              m_axis_0_tvalid,
    input  logic              m_axis_0_tready,
    input  logic [DATA_W-1:0] s_axis_0_tdata,
    input  logic              s_axis_0_tvalid,
    output logic              s_axis_0_tready
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREFETCH = 2'd1;
    localparam logic [1:0] S_STREAM   = 2'd2;
    localparam logic [1:0] S_WAIT_RES = 2'd3;

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mem [PIXELS];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic              r_tvalid;
    logic              r_s_tready;
    logic [DATA_W-1:0] r_tdata;
    logic [DATA_W-1:0] r_result;
    logic [15:0]       r_frame_count;

    logic              w_start_ok;
    logic              w_out_beat;
    logic              w_in_beat;
    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_rd_addr;

    // The cycle that shows done/timeout is already IDLE, but a start there must still be refused.
    assign w_start_ok = start && (r_state == S_IDLE) && !r_done && !r_timeout;
    assign w_out_beat = (r_state == S_STREAM) && r_tvalid && m_axis_0_tready;
    assign w_in_beat  = (r_state == S_WAIT_RES) && r_s_tready && s_axis_0_tvalid;
    assign w_wr_ok    = wr_en && !r_busy && (wr_addr <= LAST_IDX);

    // Read one pixel ahead of tdata; on a beat look two ahead so the pixel after the
    // new tdata is ready if the next cycle is also a beat.
    always_comb begin
        w_rd_addr = '0;
        if (r_state == S_PREFETCH || r_state == S_STREAM) begin
            w_rd_addr = r_idx + ADDR_W'(1) + ADDR_W'(w_out_beat);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_rd_addr <= LAST_IDX) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_tvalid      <= 1'b0;
            r_s_tready    <= 1'b0;
            r_tdata       <= '0;
            r_result      <= '0;
            r_frame_count <= '0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= S_PREFETCH;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                S_PREFETCH: begin
                    r_tdata  <= r_rd_data;
                    r_tvalid <= 1'b1;
                    r_state  <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_out_beat) begin
                        if (r_idx == LAST_IDX) begin
                            r_tvalid   <= 1'b0;
                            r_state    <= S_WAIT_RES;
                            r_cnt      <= '0;
                            r_s_tready <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_tdata <= r_rd_data;
                        end
                    end
                end
                default: begin
                    // A result beat on the final counted cycle takes priority over the abort.
                    if (w_in_beat) begin
                        r_result      <= s_axis_0_tdata;
                        r_done        <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_s_tready    <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout  <= 1'b1;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_s_tready <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign timeout         = r_timeout;
    assign result          = r_result;
    assign frame_count     = r_frame_count;
    assign m_axis_0_tdata  = r_tdata;
    assign m_axis_0_tvalid = r_tvalid;
    assign s_axis_0_tready = r_s_tready;

endmodule

// File: tb/tb_finn_frame_sequencer.sv
// tb/tb_finn_frame_sequencer.sv - scoreboard bench for finn_frame_sequencer
module tb_finn_frame_sequencer;

    localparam int PIX = 784;
    localparam int TO  = 100;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       busy, done, timeout;
    logic [7:0] result;
    logic [15:0] frame_count;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;

    finn_frame_sequencer #(.PIXELS(PIX), .DATA_W(8), .ADDR_W(10), .TIMEOUT(TO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .timeout(timeout),
        .result(result), .frame_count(frame_count),
        .m_axis_0_tdata(m_tdata), .m_axis_0_tvalid(m_tvalid), .m_axis_0_tready(m_tready),
        .s_axis_0_tdata(s_tdata), .s_axis_0_tvalid(s_tvalid), .s_axis_0_tready(s_tready)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic        is_to;
        logic [7:0]  res;
        logic [15:0] fc;
    } ev_t;

    logic [7:0] buf_m [PIX];
    logic [7:0] px_q [$];
    ev_t        ev_q [$];
    logic [7:0] res_m = '0;
    logic [15:0] fc_m = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beat_cnt = 0;
    int start_cyc = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    int to_cyc = 0;
    bit stall_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pixels and result events are popped from the scoreboard as the DUT presents them.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_tvalid", 32'(m_tvalid), 1);
                chk("stall_hold_tdata", 32'(m_tdata), 32'(prev_data));
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (m_tvalid && m_tready) begin
                if (px_q.size() == 0) begin
                    chk("beat_without_frame", 32'(m_tvalid), 0);
                end else begin
                    chk($sformatf("pixel_%0d", beat_cnt), 32'(m_tdata), 32'(px_q.pop_front()));
                end
                if (beat_cnt == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beat_cnt++;
            end
            if (done || timeout) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, done, timeout}, 0);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("event_kind", {30'd0, done, timeout}, e.is_to ? 32'd1 : 32'd2);
                    chk("result", 32'(result), 32'(e.res));
                    chk("frame_count", 32'(frame_count), 32'(e.fc));
                    chk("busy_at_end", 32'(busy), 0);
                    chk("stream_drained", px_q.size(), 0);
                    if (timeout) to_cyc = cyc;
                end
            end
        end
    end

    task automatic write_px(input int a, input logic [7:0] d);
        @(posedge ap_clk);
        #1;
        wr_en = 1'b1; wr_addr = 10'(a); wr_data = d;
        @(posedge ap_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic load_frame(input bit rnd);
        for (int i = 0; i < PIX; i++) begin
            logic [7:0] v;
            v = rnd ? 8'($urandom) : 8'(i);
            @(posedge ap_clk);
            #1;
            wr_en = 1'b1; wr_addr = 10'(i); wr_data = v;
            buf_m[i] = v;
        end
        @(posedge ap_clk);
        #1;
        wr_en = 1'b0;
        write_px(PIX + 5, 8'h55);
    endtask

    task automatic start_frame();
        @(posedge ap_clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        beat_cnt = 0;
        for (int i = 0; i < PIX; i++) px_q.push_back(buf_m[i]);
        @(posedge ap_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_stream_end();
        int n;
        n = 0;
        while (beat_cnt < PIX && n < 20000) begin
            @(posedge ap_clk);
            n++;
        end
        if (beat_cnt < PIX) bound_fail("stream_end");
    endtask

    task automatic push_done(input logic [7:0] d);
        fc_m = fc_m + 16'd1;
        res_m = d;
        ev_q.push_back({1'b0, d, fc_m});
    endtask

    task automatic respond(input logic [7:0] d, input int dly);
        int n;
        n = 0;
        while (!s_tready && n < 20000) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        if (!s_tready) begin
            bound_fail("result_ready");
        end else begin
            repeat (dly) @(posedge ap_clk);
            #1;
            push_done(d);
            s_tvalid = 1'b1; s_tdata = d;
            @(posedge ap_clk);
            #1;
            s_tvalid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ev_q.size() != 0 || busy) && n < 5000) begin
            @(posedge ap_clk);
            n++;
        end
        if (ev_q.size() != 0 || busy) bound_fail("wait_idle");
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        ap_rst_n = 1'b1;

        // Ramp frame, no stalls, result 0x07
        load_frame(1'b0);
        start_frame();
        respond(8'h07, 3);
        wait_idle();
        chk("beat_count_1", beat_cnt, PIX);
        chk("first_beat_latency", first_beat_cyc - start_cyc, 2);
        chk("last_beat_latency", last_beat_cyc - start_cyc, PIX + 1);

        // Random pixels, random stalls, result offered early and back-pressured
        load_frame(1'b1);
        stall_en = 1'b1;
        start_frame();
        push_done(8'h07);
        s_tvalid = 1'b1; s_tdata = 8'h07;
        begin
            int n;
            n = 0;
            while (!s_tready && n < 20000) begin
                @(negedge ap_clk);
                n++;
            end
            if (!s_tready) bound_fail("early_result_ready");
            @(posedge ap_clk);
            #1;
            s_tvalid = 1'b0;
        end
        wait_idle();
        stall_en = 1'b0;
        chk("beat_count_2", beat_cnt, PIX);

        // No result from the IP: timeout
        start_frame();
        wait_stream_end();
        ev_q.push_back({1'b1, res_m, fc_m});
        wait_idle();
        chk("timeout_latency", to_cyc - last_beat_cyc, TO + 1);
        chk("result_after_timeout", 32'(result), 32'h07);

        // start and write while busy are ignored
        start_frame();
        while (beat_cnt < 100) @(posedge ap_clk);
        #1;
        start = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
        @(posedge ap_clk);
        #1;
        start = 1'b0; wr_en = 1'b0;
        respond(8'($urandom), 1);
        wait_idle();
        chk("beat_count_4", beat_cnt, PIX);

        // Reset mid-stream
        start_frame();
        begin
            int n;
            n = 0;
            while (beat_cnt < 300 && n < 5000) begin
                @(posedge ap_clk);
                n++;
            end
            if (beat_cnt < 300) bound_fail("beat_300");
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_tvalid", 32'(m_tvalid), 0);
        chk("mid_rst_tdata", 32'(m_tdata), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_frame_count", 32'(frame_count), 0);
        px_q.delete();
        ev_q.delete();
        res_m = '0;
        fc_m = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        start_frame();
        respond(8'h09, 0);
        wait_idle();
        chk("beat_count_5", beat_cnt, PIX);

        // Result beat on the last timeout cycle: done wins
        start_frame();
        wait_stream_end();
        begin
            int n;
            n = 0;
            do begin
                @(posedge ap_clk);
                #1;
                n++;
            end while (cyc < last_beat_cyc + TO && n < 1000);
        end
        push_done(8'h3C);
        s_tvalid = 1'b1; s_tdata = 8'h3C;
        @(posedge ap_clk);
        #1;
        s_tvalid = 1'b0;
        wait_idle();
        chk("coincident_result", 32'(result), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation bound reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/finn_frame_sequencer.md
Name: finn_frame_sequencer

Overview:
- Controller that sequences one MNIST frame into the FINN dataflow IP (finn_design_wrapper) and captures the classification byte.
- Holds one frame in an internal BRAM that the host loads through a simple write port.
- On start, streams PIXELS bytes into the IP's s_axis_0, waits for the IP's m_axis_0 result, then latches and flags it.
- Replaces bench-driven stimulus in system builds and provides a timeout guard against a stalled IP.

Parameters:
PIXELS, 784, pixels per frame (28x28)
DATA_W, 8, pixel and result width
ADDR_W, 10, frame buffer address width; 2**ADDR_W >= PIXELS
TIMEOUT, 200000, max cycles in WAIT_RES before abort

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  write a pixel into the frame buffer
wr_addr  in  ADDR_W  pixel index, 0..PIXELS-1
wr_data  in  DATA_W  pixel value
start  in  1  single-cycle request to run one frame
busy  out  1  high from accepted start until done/timeout pulse
done  out  1  one-cycle pulse when result captured
timeout  out  1  one-cycle pulse on WAIT_RES abort
result  out  DATA_W  last captured classification
frame_count  out  16  completed frames, wraps at 0xFFFF->0
m_axis_0_tdata  out  DATA_W  pixel to IP s_axis_0_tdata
m_axis_0_tvalid  out  1  to IP s_axis_0_tvalid
m_axis_0_tready  in  1  from IP s_axis_0_tready
s_axis_0_tdata  in  DATA_W  from IP m_axis_0_tdata
s_axis_0_tvalid  in  1  from IP m_axis_0_tvalid
s_axis_0_tready  out  1  to IP m_axis_0_tready

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, timeout, m_axis_0_tvalid, s_axis_0_tready = 0; m_axis_0_tdata, result, frame_count = 0. Frame buffer contents are not cleared and survive reset.
- Frame buffer: PIXELS x DATA_W, synchronous read, 1-cycle read latency.
  - Write when wr_en && !busy; writes while busy are dropped.
  - wr_addr >= PIXELS is dropped.
- FSM:
  - IDLE: start -> PREFETCH, busy=1, read addr 0 issued. start while busy is ignored.
  - PREFETCH (1 cycle): load m_axis_0_tdata with pixel 0, assert m_axis_0_tvalid -> STREAM.
  - STREAM: on a tvalid&&tready beat, advance to the next pixel.
    - The next pixel is presented the following cycle, so back-to-back beats give 1 pixel/cycle while tready stays high.
    - tdata and tvalid are held stable while tready=0 (AXI-stream rule).
    - After beat PIXELS-1: tvalid=0 -> WAIT_RES.
  - WAIT_RES: s_axis_0_tready=1, cycle counter runs from 0.
    - First s_axis_0_tvalid beat: result <= s_axis_0_tdata, done pulse, frame_count+1 -> IDLE, tready=0.
    - Counter reaching TIMEOUT-1 without a beat: timeout pulse, result unchanged -> IDLE.
    - If the beat and the last timeout cycle coincide, the beat wins: done, not timeout.
- s_axis_0_tready is 0 outside WAIT_RES; result beats there are back-pressured, not lost.
- busy falls in the same cycle as the done/timeout pulse. A start in that cycle is ignored; a start in the next cycle is accepted.
- Latency with tready always high: start at cycle 0, first beat at cycle 2, last beat at cycle PIXELS+1.
- Reset mid-frame aborts immediately and drops tvalid. The IP must be reset with the same ap_rst_n.
- frame_count increments only on done.

Test Plan:
- Load pixels i -> i[7:0] for 0..783, pulse start, tready=1 -> 784 beats with data 0x00..0xFF repeating, first beat at cycle 2, tvalid low after beat 783; IP returns 0x07 -> result=0x07, done one cycle, frame_count=1.
- Random tready stalls (50%) during STREAM -> tdata/tvalid stable across every stall, exactly 784 beats in order, no duplicates.
- No result from IP, TIMEOUT=100 -> timeout pulses exactly 100 cycles after WAIT_RES entry, result keeps previous 0x07, busy drops, frame_count unchanged.
- start pulsed again mid-STREAM and wr_en to address 5 with 0xAA while busy -> no restart, beat count stays 784, buffer[5] unchanged on the next frame.
- ap_rst_n low at beat 300 -> all outputs 0 immediately; after release, start streams the full frame from pixel 0 with original buffer contents.
- Result beat on the same cycle as the last timeout cycle -> done=1, timeout=0, result captured.
